// File: rtl/eth_tx_ring_station.sv
// eth_tx_ring_station: store-and-forward TX ring client that sends one buffered frame per captured token
package eth_tx_ring_pkg;
    localparam int RING_DW = 32;
    localparam logic [3:0] MACPID = 4'hF;
    typedef enum logic [2:0] {
        tx_none        = 3'd0,
        tx_start_empty = 3'd1,
        tx_start       = 3'd2,
        slot_start     = 3'd3,
        tx_data        = 3'd4
    } eth_tx_stype_e;
    typedef struct packed {
        logic [3:0] pid;
    } eth_tx_header_t;
    typedef struct packed {
        eth_tx_header_t       header;
        logic [RING_DW-1:0]   data;
    } eth_tx_msg_t;
    typedef struct packed {
        eth_tx_stype_e stype;
        eth_tx_msg_t   msg;
    } eth_tx_ring_data_type;
endpackage

module eth_tx_ring_station
    import eth_tx_ring_pkg::*;
#(
    parameter logic [3:0] PID   = 4'd1,
    parameter int         DEPTH = 32,
    parameter int         DW    = RING_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  eth_tx_ring_data_type ring_in,
    output eth_tx_ring_data_type ring_out,
    input  logic                 wr_valid,
    input  logic [DW-1:0]        wr_data,
    input  logic                 wr_last,
    output logic                 wr_ready,
    output logic                 frame_pending,
    output logic                 tx_done,
    output logic                 err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {FWD, SEND, TAIL} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        commit_cnt_q, commit_cnt_d;
    logic [DEPTH-1:0]     last_q, last_d;
    logic [DW-1:0]        mem_q [DEPTH];
    eth_tx_ring_data_type ring_out_q, ring_out_d;
    logic                 tx_done_q, tx_done_d, err_q, err_d;
    logic [AW-1:0]        wr_addr, rd_addr;
    logic                 full, wr_en, rd_en, rd_last, overflow, capture;

    assign wr_addr       = wr_ptr_q[AW-1:0];
    assign rd_addr       = rd_ptr_q[AW-1:0];
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
    assign wr_ready      = !full;
    assign wr_en         = wr_valid && !full;
    // When full nothing is accepted, so any wr_valid here lacks an accepted wr_last.
    assign overflow      = full && (commit_cnt_q == '0) && wr_valid;
    assign rd_en         = state_q == SEND;
    assign rd_last       = rd_en && last_q[rd_addr];
    // Eligibility uses the registered count, so a frame committed this very cycle waits.
    assign capture       = (ring_in.stype == tx_start_empty) && (commit_cnt_q != '0);
    assign frame_pending = commit_cnt_q != '0;
    assign ring_out      = ring_out_q;
    assign tx_done       = tx_done_q;
    assign err           = err_q;

    // Buffer pointers, committed-frame count and last-beat markers.
    always_comb begin
        wr_ptr_d     = overflow ? rd_ptr_q : wr_ptr_q + PW'(wr_en);
        rd_ptr_d     = rd_ptr_q + PW'(rd_en);
        commit_cnt_d = commit_cnt_q + PW'(wr_en && wr_last) - PW'(rd_last);
        last_d       = last_q;
        if (wr_en) last_d[wr_addr] = wr_last;
    end

    // Ring FSM: forward, or capture the token and stream header, payload and a closing tx_none.
    always_comb begin
        state_d    = state_q;
        ring_out_d = ring_in;
        tx_done_d  = 1'b0;
        err_d      = overflow;
        case (state_q)
            FWD: if (capture) begin
                state_d                   = SEND;
                ring_out_d                = '0;
                ring_out_d.stype          = tx_start;
                ring_out_d.msg.header.pid = PID;
            end
            SEND: begin
                ring_out_d          = '0;
                ring_out_d.stype    = tx_data;
                ring_out_d.msg.data = RING_DW'(mem_q[rd_addr]);
                err_d               = overflow || (ring_in.stype != tx_none);
                tx_done_d           = rd_last;
                state_d             = rd_last ? TAIL : SEND;
            end
            default: begin
                ring_out_d = '0;
                err_d      = overflow || (ring_in.stype != tx_none);
                state_d    = FWD;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FWD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_cnt_q <= '0;
            last_q       <= '0;
            ring_out_q   <= '0;
            tx_done_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_cnt_q <= commit_cnt_d;
            last_q       <= last_d;
            ring_out_q   <= ring_out_d;
            tx_done_q    <= tx_done_d;
            err_q        <= err_d;
        end
    end

    // Payload storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_eth_tx_ring_station.sv
// tb_eth_tx_ring_station: directed table-driven and sequence checks of the ring station
module tb_eth_tx_ring_station;
    import eth_tx_ring_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [3:0] PID   = 4'd5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    eth_tx_ring_data_type ring_in = '0;
    eth_tx_ring_data_type ring_out;
    logic                 wr_valid = 1'b0;
    logic [31:0]          wr_data = '0;
    logic                 wr_last = 1'b0;
    logic                 wr_ready, frame_pending, tx_done, err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        eth_tx_ring_data_type rin;
        eth_tx_ring_data_type rout;
        logic                 err;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    eth_tx_ring_station #(.PID(PID), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ring_in(ring_in), .ring_out(ring_out),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .frame_pending(frame_pending), .tx_done(tx_done), .err(err)
    );

    function automatic eth_tx_ring_data_type mk(eth_tx_stype_e s, logic [3:0] p, logic [31:0] d);
        eth_tx_ring_data_type w;
        w.stype          = s;
        w.msg.header.pid = p;
        w.msg.data       = d;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_ring(input string nm, input eth_tx_ring_data_type exp);
        checks++;
        if (ring_out !== exp) begin
            errors++;
            $display("FAIL %s: got stype=%0d pid=%0d data=%h expected stype=%0d pid=%0d data=%h",
                     nm, ring_out.stype, ring_out.msg.header.pid, ring_out.msg.data,
                     exp.stype, exp.msg.header.pid, exp.msg.data);
        end
    endtask

    task automatic wr_beat(input logic [31:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic send_frame(input int n);
        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        tick();
        ring_in = '0;
        chk_ring("header", mk(tx_start, PID, 32'd0));
        chk("tx_done_hdr", 32'(tx_done), 32'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_ring("payload", mk(tx_data, 4'd0, exp_q.pop_front()));
            chk("tx_done_beat", 32'(tx_done), 32'(i == n - 1));
        end
        tick();
        chk_ring("tail", mk(tx_none, 4'd0, 32'd0));
        chk("tx_done_tail", 32'(tx_done), 32'd0);
        chk("err_frame", 32'(err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{mk(tx_start_empty, 4'd0, 32'd0), mk(tx_start_empty, 4'd0, 32'd0), 1'b0};
        vecs[1] = '{mk(tx_none, 4'd0, 32'd0), mk(tx_none, 4'd0, 32'd0), 1'b0};
        vecs[2] = '{mk(slot_start, 4'd3, 32'd0), mk(slot_start, 4'd3, 32'd0), 1'b0};
        vecs[3] = '{mk(tx_data, 4'd0, 32'hAA), mk(tx_data, 4'd0, 32'hAA), 1'b0};
        vecs[4] = '{mk(tx_start, 4'd7, 32'h5), mk(tx_start, 4'd7, 32'h5), 1'b0};

        tick();
        tick();
        reset = 1'b0;
        chk_ring("reset_ring_out", mk(tx_none, 4'd0, 32'd0));
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_pending", 32'(frame_pending), 32'd0);
        chk("reset_tx_done", 32'(tx_done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        foreach (vecs[i]) begin
            ring_in = vecs[i].rin;
            tick();
            chk_ring("passthrough", vecs[i].rout);
            chk("passthrough_err", 32'(err), 32'(vecs[i].err));
        end
        ring_in = '0;

        wr_beat(32'h11, 1'b0);
        wr_beat(32'h22, 1'b0);
        chk("pending_before_last", 32'(frame_pending), 32'd0);
        wr_beat(32'h33, 1'b1);
        chk("pending_after_last", 32'(frame_pending), 32'd1);
        send_frame(3);
        chk("pending_single_done", 32'(frame_pending), 32'd0);

        wr_beat(32'hA1, 1'b0);
        wr_beat(32'hA2, 1'b1);
        wr_beat(32'hB1, 1'b1);
        send_frame(2);
        chk("pending_between", 32'(frame_pending), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ring("idle_between", mk(tx_none, 4'd0, 32'd0));
        end
        send_frame(1);
        chk("pending_two_done", 32'(frame_pending), 32'd0);

        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        wr_beat(32'h51, 1'b1);
        ring_in = '0;
        chk_ring("same_cycle_commit_fwd", mk(tx_start_empty, 4'd0, 32'd0));
        chk("same_cycle_pending", 32'(frame_pending), 32'd1);
        send_frame(1);

        for (int i = 0; i < DEPTH; i++) begin
            chk("ready_filling", 32'(wr_ready), 32'd1);
            wr_beat(32'hC0 + 32'(i), 1'b0);
        end
        exp_q.delete();
        chk("ready_full", 32'(wr_ready), 32'd0);
        chk("err_before_ovf", 32'(err), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD;
        tick();
        wr_valid = 1'b0;
        chk("err_overflow", 32'(err), 32'd1);
        chk("ready_after_flush", 32'(wr_ready), 32'd1);
        tick();
        chk("err_pulse_end", 32'(err), 32'd0);
        chk("pending_after_flush", 32'(frame_pending), 32'd0);
        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        tick();
        ring_in = '0;
        chk_ring("token_fwd_after_flush", mk(tx_start_empty, 4'd0, 32'd0));

        wr_beat(32'h31, 1'b0);
        wr_beat(32'h32, 1'b0);
        wr_beat(32'h33, 1'b1);
        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        tick();
        chk_ring("viol_header", mk(tx_start, PID, 32'd0));
        ring_in = mk(slot_start, 4'd2, 32'h99);
        tick();
        ring_in = '0;
        chk_ring("viol_payload0", mk(tx_data, 4'd0, 32'h31));
        chk("viol_err", 32'(err), 32'd1);
        tick();
        chk_ring("viol_payload1", mk(tx_data, 4'd0, 32'h32));
        chk("viol_err_clear", 32'(err), 32'd0);
        tick();
        chk_ring("viol_payload2", mk(tx_data, 4'd0, 32'h33));
        chk("viol_tx_done", 32'(tx_done), 32'd1);
        tick();
        chk_ring("viol_tail", mk(tx_none, 4'd0, 32'd0));
        exp_q.delete();

        wr_beat(32'h41, 1'b0);
        wr_beat(32'h42, 1'b0);
        wr_beat(32'h43, 1'b1);
        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        tick();
        ring_in = '0;
        tick();
        chk_ring("rst_send_beat", mk(tx_data, 4'd0, 32'h41));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk_ring("rst_send_ring_out", mk(tx_none, 4'd0, 32'd0));
        chk("rst_send_pending", 32'(frame_pending), 32'd0);
        chk("rst_send_ready", 32'(wr_ready), 32'd1);
        chk("rst_send_tx_done", 32'(tx_done), 32'd0);
        ring_in = mk(tx_start_empty, 4'd0, 32'd0);
        tick();
        ring_in = '0;
        chk_ring("rst_token_fwd", mk(tx_start_empty, 4'd0, 32'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_tx_ring_station.md
# eth_tx_ring_station

Store-and-forward client node on the 1000BASE-T Ethernet TX DMA token ring; the sending end of the ring protocol whose terminus sits in front of the MAC TX FIFO. A local producer writes whole frames into an internal buffer. When a committed frame is waiting and the circulating empty token (`tx_start_empty`) arrives, the station absorbs the token and emits header + payload beats. It then ends the frame with `tx_none` so the ring master can regenerate the token. At all other times it forwards ring traffic with one register stage.

## Interface
- `PID`, default 1: value written to `msg.header.pid` of the header beat; MACPID selects a MAC-header-updating frame.
- `DEPTH`, default 32: buffer depth in beats, power of 2, ≥ 4; maximum frame payload length.
- `DW`, default = width of `msg.data`: payload beat width.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `ring_in`  in  `eth_tx_ring_data_type`: upstream ring beat.
- `ring_out`  out  `eth_tx_ring_data_type`: downstream ring beat, registered.
- `wr_valid`  in  1: producer beat valid.
- `wr_data`  in  DW: producer payload beat.
- `wr_last`  in  1: final beat of frame.
- `wr_ready`  out  1: buffer can accept a beat; equals !full.
- `frame_pending`  out  1: at least one committed frame buffered.
- `tx_done`  out  1: one-cycle pulse when the last payload beat of a frame leaves on `ring_out`.
- `err`  out  1: one-cycle pulse on a protocol violation or overflow flush.

## Operation
- **Buffer**
  - Circular DEPTH×DW RAM with write and read pointers of log2(DEPTH)+1 bits (wrap bit distinguishes full from empty).
  - A beat is written when `wr_valid && wr_ready`.
  - `commit_cnt` increments on an accepted `wr_last` beat and decrements when a frame's last beat is sent; both in the same cycle leaves it unchanged.
  - Last-beat positions are held in a DEPTH-bit marker array indexed by write address.
- **Overflow**
  - Condition: the buffer is full, `commit_cnt == 0`, and `wr_valid` is asserted without an accepted `wr_last`.
  - Response: flush the uncommitted beats (write pointer returns to read pointer) and pulse `err`.
  - Committed frames are never flushed.
- **FSM states**
  - FWD: `ring_out <= ring_in`, except that a `tx_start_empty` arriving while `commit_cnt > 0` is not forwarded. Instead `ring_out <= header beat` and the FSM goes to SEND.
  - SEND: one payload beat per cycle is emitted with stype `tx_data`, `msg.data` = buffer word. After the beat marked last, go to TAIL.
  - TAIL: `ring_out <= tx_none` for one cycle, `tx_done` pulses the same cycle as the last payload beat, then return to FWD.
- **Header beat**
  - stype `tx_start`, `msg.data = '0`, then `msg.header.pid = PID`.
  - Beats with stype `tx_start`, `slot_start`, or `tx_data` from other stations are forwarded untouched in FWD.
- **Token policy**
  - One frame per token capture.
  - A second pending frame waits for the next token, even if `ring_in` carries the token during TAIL.
- **Ring input in SEND/TAIL**
  - `ring_in` is discarded.
  - Any stype other than `tx_none` pulses `err`; this covers a token duplicate or upstream traffic without a token.
- **Payload streaming**
  - Payload is contiguous; the frame is fully buffered before transmission, so there are no bubbles.
  - Writes continue concurrently during SEND.
- **Reset**
  - Empties the buffer, clears `commit_cnt` and the markers, enters FWD, and drives `ring_out` = {`tx_none`, data 0}.
  - `tx_done` = 0, `err` = 0, `frame_pending` = 0, `wr_ready` = 1 from the cycle after reset.
  - Reset during SEND truncates the frame; the next `ring_out` is `tx_none`.

## Timing
- Forward latency: 1 cycle, `ring_in` at edge t appears on `ring_out` after edge t+1.
- Token at cycle t with a frame pending: header at t+1, N payload beats at t+2..t+1+N, `tx_none` at t+2+N.
- `tx_done` is high in cycle t+1+N.
- `frame_pending` rises the cycle after the accepted `wr_last` beat. It falls the cycle after the last beat is read, only if `commit_cnt` reaches 0.
- A frame whose `wr_last` is accepted in the same cycle the token arrives is not eligible; the decision uses the registered `commit_cnt`.
- `wr_ready` is combinational from the pointers; a same-cycle read does not raise it.
- Read is issued one cycle ahead of emission. RAM may be registered-read; the header cycle hides the latency.

## Test plan
- Passthrough:
  - Stimulus, no frame: `ring_in` sequence `tx_start_empty`, `tx_none`, `slot_start`(pid=3), `tx_data` 0xAA.
  - Required response: the same sequence on `ring_out` delayed 1 cycle; `err` = 0.
- Single frame:
  - Stimulus: write 3 beats 0x11, 0x22, 0x33 (`wr_last` on 0x33); token at cycle t.
  - Required response: `tx_start` pid=PID at t+1; `tx_data` 0x11/0x22/0x33 at t+2..t+4; `tx_none` at t+5; `tx_done` at t+4; token not forwarded.
- Two frames:
  - Stimulus: two frames queued; tokens at t and t+10.
  - Required response: the first frame only after t; the second after t+10; `frame_pending` drops after the second `tx_done`.
- Full/overflow:
  - Stimulus: DEPTH beats without `wr_last`, then one more `wr_valid`.
  - Required response: `wr_ready` = 0 when full; flush; `err` pulse; next token forwarded unchanged.
- Violation:
  - Stimulus: `ring_in` = `slot_start` during SEND.
  - Required response: `err` pulse; `ring_out` payload unaffected.
- Reset mid-SEND:
  - Stimulus: `reset` asserted during SEND.
  - Required response: `ring_out` = `tx_none` next cycle; `frame_pending` = 0; `wr_ready` = 1.
